// File: rtl/mt9v034_sync_decoder.sv
// MT9V034 stereo sync-code decoder.
// Parses the embedded sync codes carried on the left-camera byte of the
// deserialized word stream and re-emits pixel pairs as AXI4-Stream video
// (tuser = start of frame, tlast = end of line), with frame geometry,
// lock, overflow and protocol-error status.
// The input cannot stall. A one-word hold register delays each pixel so
// that the line-end code can tag the final pixel with tlast.
module mt9v034_sync_decoder #(
    parameter int CNT_W = 11,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    input  logic [15:0]      in_data,
    output logic [15:0]      m_tdata,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic             m_tuser,
    output logic             m_tlast,
    output logic             sync_lock,
    output logic             frame_done,
    output logic [CNT_W-1:0] frame_width,
    output logic [CNT_W-1:0] frame_height,
    output logic             overflow,
    output logic [ERR_W-1:0] err_count
);

    typedef enum logic [2:0] {
        ST_SEQ0,
        ST_SEQ1,
        ST_SEQ2,
        ST_FRAME,
        ST_LINE
    } state_t;

    state_t state, state_nxt;

    logic [7:0]       code;
    logic             do_lock;
    logic             do_line_start;
    logic             do_frame_end;
    logic             do_pixel;
    logic             do_line_end;
    logic             do_err;
    logic             push;
    logic             o_free;

    logic             h_vld;
    logic             h_sof;
    logic [15:0]      h_data;
    logic             sof_pend;
    logic [CNT_W-1:0] pix_cnt;
    logic [CNT_W-1:0] line_cnt;
    logic [CNT_W-1:0] last_width;

    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [ERR_W-1:0] err_inc(input logic [ERR_W-1:0] v);
        return (&v) ? v : v + ERR_W'(1);
    endfunction

    assign code   = in_data[7:0];
    // The last pixel of a line leaves the hold register on the line-end code.
    assign push   = (do_pixel & h_vld) | do_line_end;
    assign o_free = ~m_tvalid | m_tready;

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= ST_SEQ0;
        else         state <= state_nxt;
    end

    // Next-state decode and per-word action strobes; idle slots change nothing.
    always_comb begin
        state_nxt     = state;
        do_lock       = 1'b0;
        do_line_start = 1'b0;
        do_frame_end  = 1'b0;
        do_pixel      = 1'b0;
        do_line_end   = 1'b0;
        do_err        = 1'b0;
        if (in_valid) begin
            unique case (state)
                ST_SEQ0: begin
                    if (code == 8'hFF) state_nxt = ST_SEQ1;
                end
                ST_SEQ1: begin
                    if (code == 8'h00)      state_nxt = ST_SEQ2;
                    else if (code == 8'hFF) state_nxt = ST_SEQ1;
                    else                    state_nxt = ST_SEQ0;
                end
                ST_SEQ2: begin
                    if (code == 8'hFF) begin
                        state_nxt = ST_FRAME;
                        do_lock   = 1'b1;
                    end else begin
                        state_nxt = ST_SEQ0;
                    end
                end
                ST_FRAME: begin
                    if (code == 8'h01) begin
                        state_nxt     = ST_LINE;
                        do_line_start = 1'b1;
                    end else if (code == 8'h03) begin
                        state_nxt    = ST_SEQ0;
                        do_frame_end = 1'b1;
                    end else if (code != 8'h04) begin
                        do_err = 1'b1;
                    end
                end
                ST_LINE: begin
                    if (code == 8'h02) begin
                        // A line end with nothing held is a zero-pixel line.
                        if (h_vld) begin
                            state_nxt   = ST_FRAME;
                            do_line_end = 1'b1;
                        end else begin
                            do_err = 1'b1;
                        end
                    end else if (code == 8'h00 || code == 8'h01 ||
                                 code == 8'h03 || code == 8'hFF) begin
                        do_err = 1'b1;
                    end else begin
                        do_pixel = 1'b1;
                    end
                end
                default: state_nxt = ST_SEQ0;
            endcase
            if (do_err) state_nxt = ST_SEQ0;
        end
    end

    // Hold register, line/pixel counters, geometry, lock and error status.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            h_vld        <= 1'b0;
            h_sof        <= 1'b0;
            h_data       <= '0;
            sof_pend     <= 1'b0;
            pix_cnt      <= '0;
            line_cnt     <= '0;
            last_width   <= '0;
            sync_lock    <= 1'b0;
            frame_done   <= 1'b0;
            frame_width  <= '0;
            frame_height <= '0;
            err_count    <= '0;
        end else begin
            frame_done <= 1'b0;
            if (do_lock) begin
                sync_lock <= 1'b1;
                sof_pend  <= 1'b1;
            end
            if (do_line_start) pix_cnt <= '0;
            if (do_frame_end) begin
                frame_height <= line_cnt;
                frame_width  <= last_width;
                frame_done   <= 1'b1;
                sync_lock    <= 1'b0;
                line_cnt     <= '0;
            end
            if (do_pixel) begin
                h_vld    <= 1'b1;
                h_data   <= in_data;
                h_sof    <= sof_pend;
                sof_pend <= 1'b0;
                pix_cnt  <= cnt_inc(pix_cnt);
            end
            if (do_line_end) begin
                h_vld      <= 1'b0;
                last_width <= pix_cnt;
                line_cnt   <= cnt_inc(line_cnt);
            end
            if (do_err) begin
                err_count <= err_inc(err_count);
                h_vld     <= 1'b0;
                sof_pend  <= 1'b0;
                sync_lock <= 1'b0;
                line_cnt  <= '0;
            end
        end
    end

    // Output register: accepts a push only when free, otherwise drops it and flags overflow.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_tvalid <= 1'b0;
            m_tdata  <= '0;
            m_tuser  <= 1'b0;
            m_tlast  <= 1'b0;
            overflow <= 1'b0;
        end else if (push) begin
            if (o_free) begin
                m_tvalid <= 1'b1;
                m_tdata  <= h_data;
                m_tuser  <= h_sof;
                m_tlast  <= do_line_end;
            end else begin
                overflow <= 1'b1;
            end
        end else if (m_tvalid && m_tready) begin
            m_tvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mt9v034_sync_decoder.sv
// Scoreboard bench for mt9v034_sync_decoder: stimulus tasks queue the
// beats each frame should produce, a negedge monitor pops them on every
// output handshake.
module tb_mt9v034_sync_decoder;

    localparam int CNT_W = 11;
    localparam int ERR_W = 8;

    logic             clk = 1'b0;
    logic             resetn;
    logic             in_valid;
    logic [15:0]      in_data;
    logic [15:0]      m_tdata;
    logic             m_tvalid;
    logic             m_tready;
    logic             m_tuser;
    logic             m_tlast;
    logic             sync_lock;
    logic             frame_done;
    logic [CNT_W-1:0] frame_width;
    logic [CNT_W-1:0] frame_height;
    logic             overflow;
    logic [ERR_W-1:0] err_count;

    typedef struct packed {
        logic [15:0] d;
        logic        u;
        logic        l;
    } beat_t;

    beat_t exp_q[$];
    beat_t mon_e;
    int    total    = 0;
    int    bad      = 0;
    int    done_cnt = 0;
    bit    gaps_en  = 1'b0;

    mt9v034_sync_decoder #(.CNT_W(CNT_W), .ERR_W(ERR_W)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .m_tdata      (m_tdata),
        .m_tvalid     (m_tvalid),
        .m_tready     (m_tready),
        .m_tuser      (m_tuser),
        .m_tlast      (m_tlast),
        .sync_lock    (sync_lock),
        .frame_done   (frame_done),
        .frame_width  (frame_width),
        .frame_height (frame_height),
        .overflow     (overflow),
        .err_count    (err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Output monitor: every handshake must match the next queued beat.
    always @(negedge clk) begin
        if (resetn) begin
            if (frame_done) done_cnt++;
            if (m_tvalid && m_tready) begin
                chk("beat_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    chk("beat_data", 32'(m_tdata), 32'(mon_e.d));
                    chk("beat_user", 32'(m_tuser), 32'(mon_e.u));
                    chk("beat_last", 32'(m_tlast), 32'(mon_e.l));
                end
            end
        end
    end

    task automatic idle();
        logic [15:0] r;
        r        = 16'($urandom());
        in_valid = 1'b0;
        in_data  = r;
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [15:0] w);
        if (gaps_en && $urandom_range(0, 3) == 0) idle();
        in_valid = 1'b1;
        in_data  = w;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic code(input logic [7:0] c);
        put({c ^ 8'h5A, c});
    endtask

    task automatic pix(input logic [15:0] w, input bit sof, input bit last, input bit expect_out);
        beat_t e;
        e.d = w;
        e.u = sof;
        e.l = last;
        if (expect_out) exp_q.push_back(e);
        put(w);
    endtask

    task automatic sync3();
        code(8'hFF);
        code(8'h00);
        code(8'hFF);
    endtask

    // Camera model: blanking, frame start, lines of pixels value base+x+y.
    task automatic send_frame(input int w, input int h, input int base, input int hb, input int vb);
        logic [7:0] v;
        repeat (vb) code(8'h04);
        sync3();
        for (int y = 0; y < h; y++) begin
            repeat (hb) code(8'h04);
            code(8'h01);
            for (int x = 0; x < w; x++) begin
                v = 8'(base + x + y);
                pix({v, v}, (x == 0) && (y == 0), x == w - 1, 1'b1);
            end
            code(8'h02);
        end
        repeat (vb) code(8'h04);
        code(8'h03);
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) idle();
        chk("drain", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_tvalid"}, 32'(m_tvalid), 32'd0);
        chk({tag, "_tuser"}, 32'(m_tuser), 32'd0);
        chk({tag, "_tlast"}, 32'(m_tlast), 32'd0);
        chk({tag, "_tdata"}, 32'(m_tdata), 32'd0);
        chk({tag, "_lock"}, 32'(sync_lock), 32'd0);
        chk({tag, "_done"}, 32'(frame_done), 32'd0);
        chk({tag, "_width"}, 32'(frame_width), 32'd0);
        chk({tag, "_height"}, 32'(frame_height), 32'd0);
        chk({tag, "_ovf"}, 32'(overflow), 32'd0);
        chk({tag, "_err"}, 32'(err_count), 32'd0);
    endtask

    initial begin
        logic [15:0] q;
        resetn   = 1'b0;
        in_valid = 1'b0;
        in_data  = 16'h0000;
        m_tready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("rst");
        resetn = 1'b1;
        idle();

        // Mid-frame start without sync: nothing may come out.
        gaps_en = 1'b1;
        code(8'h01);
        for (int i = 0; i < 6; i++) put({8'h20 + 8'(i), 8'h20 + 8'(i)});
        code(8'h02);
        code(8'h01);
        put(16'h3131);
        code(8'h02);
        code(8'h03);
        chk("nosync_lock", 32'(sync_lock), 32'd0);

        // Full 64x48 frame.
        send_frame(64, 48, 4, 24, 24);
        idle();
        idle();
        chk("f1_done", 32'(done_cnt), 32'd1);
        chk("f1_width", 32'(frame_width), 32'd64);
        chk("f1_height", 32'(frame_height), 32'd48);
        chk("f1_err", 32'(err_count), 32'd0);
        chk("f1_lock", 32'(sync_lock), 32'd0);
        drain();

        // Repeated 255 before 0, single-pixel single-line frame.
        code(8'hFF);
        code(8'hFF);
        code(8'h00);
        code(8'hFF);
        chk("rep_lock", 32'(sync_lock), 32'd1);
        code(8'h01);
        pix(16'h1010, 1'b1, 1'b1, 1'b1);
        code(8'h02);
        code(8'h03);
        idle();
        idle();
        chk("f2_done", 32'(done_cnt), 32'd2);
        chk("f2_width", 32'(frame_width), 32'd1);
        chk("f2_height", 32'(frame_height), 32'd1);
        drain();

        // Partial start sequence must not lock.
        code(8'hFF);
        code(8'h00);
        code(8'h07);
        code(8'h01);
        put(16'h2020);
        code(8'h02);
        idle();
        chk("partial_lock", 32'(sync_lock), 32'd0);
        chk("partial_err", 32'(err_count), 32'd0);

        // Reserved code mid-line: error, held pixel lost.
        sync3();
        chk("e_lock_on", 32'(sync_lock), 32'd1);
        code(8'h01);
        for (int i = 0; i < 5; i++) pix({8'hC0 + 8'(i), 8'h10 + 8'(i)}, i == 0, 1'b0, i < 4);
        code(8'h03);
        chk("e_err", 32'(err_count), 32'd1);
        chk("e_lock_off", 32'(sync_lock), 32'd0);
        chk("e_width_kept", 32'(frame_width), 32'd1);
        chk("e_height_kept", 32'(frame_height), 32'd1);
        drain();
        send_frame(8, 3, 8'h40, 2, 2);
        idle();
        idle();
        chk("f3_done", 32'(done_cnt), 32'd3);
        chk("f3_width", 32'(frame_width), 32'd8);
        chk("f3_height", 32'(frame_height), 32'd3);
        chk("f3_err", 32'(err_count), 32'd1);
        drain();

        // Back-pressure: q1 and q2 dropped, q0 held stable.
        gaps_en = 1'b0;
        sync3();
        code(8'h01);
        pix({8'h90, 8'h30}, 1'b1, 1'b0, 1'b1);
        chk("ovf_before", 32'(overflow), 32'd0);
        m_tready = 1'b0;
        pix({8'h91, 8'h31}, 1'b0, 1'b0, 1'b0);
        pix({8'h92, 8'h32}, 1'b0, 1'b0, 1'b0);
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_hold_valid", 32'(m_tvalid), 32'd1);
        chk("ovf_hold_data", 32'(m_tdata), 32'h9030);
        pix({8'h93, 8'h33}, 1'b0, 1'b0, 1'b1);
        chk("ovf_hold_data2", 32'(m_tdata), 32'h9030);
        chk("ovf_hold_user", 32'(m_tuser), 32'd1);
        m_tready = 1'b1;
        for (int i = 4; i < 10; i++) begin
            q = {8'h90 + 8'(i), 8'h30 + 8'(i)};
            pix(q, 1'b0, i == 9, 1'b1);
        end
        code(8'h02);
        code(8'h01);
        code(8'h02);
        chk("empty_line_err", 32'(err_count), 32'd2);
        chk("ovf_sticky", 32'(overflow), 32'd1);
        chk("empty_line_lock", 32'(sync_lock), 32'd0);
        drain();

        // Asynchronous reset in the middle of a line.
        gaps_en = 1'b1;
        sync3();
        code(8'h01);
        for (int i = 0; i < 3; i++) pix({8'h60 + 8'(i), 8'h60 + 8'(i)}, i == 0, 1'b0, 1'b1);
        #2;
        resetn = 1'b0;
        #1;
        exp_q.delete();
        chk_reset_vals("midrst");
        @(posedge clk);
        #1;
        resetn = 1'b1;
        code(8'h01);
        put(16'h2121);
        code(8'h02);
        code(8'h03);
        chk("post_rst_lock", 32'(sync_lock), 32'd0);
        send_frame(4, 2, 8'h70, 2, 2);
        idle();
        idle();
        chk("f4_width", 32'(frame_width), 32'd4);
        chk("f4_height", 32'(frame_height), 32'd2);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mt9v034_sync_decoder.md
Name: mt9v034_sync_decoder

Overview:
Sits directly downstream of the stereo MT9V034 LVDS deserializer unit. It consumes the deserialized 16-bit word stream (one 8-bit sample per camera per pixel slot) and parses the sensor's embedded sync codes. It emits an AXI4-Stream video stream with tuser=SOF and tlast=EOL, plus frame-geometry and error status. Input cannot stall; output back-pressure beyond one word is reported as overflow.

Parameters:
CNT_W, 11, width of pixel/line counters and geometry outputs
ERR_W, 8, width of saturating protocol-error counter

Ports:
clk  in  1  pixel-word clock (deserializer output domain)
resetn  in  1  asynchronous active-low reset
in_valid  in  1  one deserialized pixel slot present this cycle
in_data  in  16  [7:0] left sample, [15:8] right sample; sync decode uses [7:0] only
m_tdata  out  16  pixel pair, same byte order as in_data
m_tvalid  out  1  AXI4-Stream valid
m_tready  in  1  AXI4-Stream ready
m_tuser  out  1  start of frame (first pixel of frame)
m_tlast  out  1  end of line (last pixel of line)
sync_lock  out  1  high from frame-start sequence until frame end or error
frame_done  out  1  one-cycle pulse on valid frame-end code
frame_width  out  CNT_W  pixels in last completed line of last completed frame
frame_height  out  CNT_W  lines in last completed frame
overflow  out  1  sticky; pixel dropped due to back-pressure
err_count  out  ERR_W  saturating protocol-error count

Behaviour:
- Codes (left byte): 255,0,255 = frame start; 1 = line start; 2 = line end; 3 = frame end; 4 = blanking; 5..254 and 4 inside a line = pixel; 0,1,3,255 inside a line = reserved → error.
- Only cycles with in_valid=1 are examined; in_valid=0 changes no state.
- FSM SEARCH (sub-state seq 0/1/2): seq0: 255→seq1. seq1: 0→seq2; 255 stays seq1; other→seq0. seq2: 255→FRAME, sync_lock=1, sof_pend=1; other→seq0.
- FRAME: 1→LINE, pix_cnt=0. 3→SEARCH: frame_height<=line_cnt, frame_width<=last_width, frame_done pulse, sync_lock=0, line_cnt=0. 4→stay. Other→error.
- LINE, pixel word: if hold H valid, push H (tlast=0); then H<=word, H.sof<=sof_pend; sof_pend<=0; pix_cnt++ (saturate at all-ones).
- LINE, code 2: if H valid, push H with tlast=1, last_width<=pix_cnt, line_cnt++, →FRAME. If H empty (zero-pixel line) → error.
- Error: err_count++ (saturate), H discarded, sync_lock=0, line_cnt=0, →SEARCH seq0. Geometry outputs not updated.
- Push rule: if O empty or (m_tvalid & m_tready) this cycle, O<=H. Otherwise the pushed word is dropped and overflow<=1 (sticky until reset). A dropped SOF word loses its tuser; no retry.
- O clears when accepted with no concurrent push.
- Latency: a pixel appears on m_tdata one in_valid word after its own arrival plus one clk (register O).
- Reset (async, resetn=0): state SEARCH/seq0, H/O empty, m_tvalid=0, m_tuser=0, m_tlast=0, m_tdata=0, sync_lock=0, frame_done=0, frame_width=0, frame_height=0, overflow=0, err_count=0, counters 0.
- Reset mid-frame: everything is discarded; decoding restarts at the next 255,0,255.
- m_tdata/m_tuser/m_tlast stay stable while m_tvalid=1 and m_tready=0.

Test Plan:
- Stereo camera model (HPX=64, VPX=48, HBLANK=VBLANK=24) → deserializer → DUT, m_tready=1 → first beat 0x0404 with tuser=1. Line 0 ends 0x4343 with tlast=1. Line 1 starts 0x0505. frame_done pulses; frame_width=64, frame_height=48; err_count=0.
- Stream starting mid-frame, no sync yet → no m_tvalid until 255,0,255 is seen. First output has tuser=1.
- Sequence 255,255,0,255,1,0x10,2 → single beat 0x1010 with tuser=1 and tlast=1. Partial sequences 255,0,7 → no lock.
- Reserved 0x03 injected mid-line → err_count=1, sync_lock=0, held pixel not emitted. Next frame decodes normally.
- m_tready=0 for 3 pixel slots in a line → overflow=1, output beats held stable, later beats continue. Line 1,2 with no pixels → err_count increments.
- resetn asserted mid-line → all outputs at reset values immediately. After release, output resumes only at the next frame start, with tuser=1.
